// File: rtl/regfile_param.sv
// Parameterized register file: write port with same-cycle read bypass, two combinational
// read ports, one register mirrored to io_out and loadable from io_in, and a handshaked
// sequential dump of the stored contents.
module regfile_param #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned IO_REG  = 30,
   parameter bit          ZERO_R0 = 1'b1,
   localparam int unsigned AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             we,
   input  logic [AW-1:0]    writeaddr,
   input  logic [WIDTH-1:0] writedata,
   input  logic [AW-1:0]    readaddr1,
   input  logic [AW-1:0]    readaddr2,
   output logic [WIDTH-1:0] readdata1,
   output logic [WIDTH-1:0] readdata2,
   input  logic [WIDTH-1:0] io_in,
   input  logic             io_load,
   output logic [WIDTH-1:0] io_out,
   input  logic             dump_start,
   input  logic             dump_ready,
   output logic             dump_valid,
   output logic [AW-1:0]    dump_addr,
   output logic [WIDTH-1:0] dump_data,
   output logic             dump_busy,
   output logic             dump_done
);

   localparam logic [AW-1:0] IoIdx   = AW'(IO_REG);
   localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} dump_state_e;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];

   dump_state_e   state_q;
   logic [AW-1:0] dump_addr_q;
   logic          dump_valid_q;
   logic          dump_busy_q;
   logic          dump_done_q;

   logic wr_zero_blocked;
   logic io_collides;
   logic we_eff;
   logic io_load_eff;

   // A write is effective unless it targets a hardwired-zero r0 or loses to io_load.
   assign wr_zero_blocked = ZERO_R0 && (writeaddr == '0);
   assign io_collides     = io_load && (writeaddr == IoIdx);
   assign we_eff          = we && !wr_zero_blocked && !io_collides;
   assign io_load_eff     = io_load && !(ZERO_R0 && (IoIdx == '0));

   // Next-state of the register array: io_load has priority over the write port.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we_eff) begin
         regs_d[writeaddr] = writedata;
      end
      if (io_load_eff) begin
         regs_d[IoIdx] = io_in;
      end
   end

   // Register array storage with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read port 1: bypass reflects only the effective write-port data, never io_load.
   always_comb begin
      readdata1 = regs_q[readaddr1];
      if (we_eff && (writeaddr == readaddr1)) begin
         readdata1 = writedata;
      end
      if (ZERO_R0 && (readaddr1 == '0)) begin
         readdata1 = '0;
      end
   end

   // Read port 2: same rules as port 1, independently decoded.
   always_comb begin
      readdata2 = regs_q[readaddr2];
      if (we_eff && (writeaddr == readaddr2)) begin
         readdata2 = writedata;
      end
      if (ZERO_R0 && (readaddr2 == '0)) begin
         readdata2 = '0;
      end
   end

   assign io_out = regs_q[IoIdx];

   // Dump data is the stored value at the current beat, never bypassed.
   always_comb begin
      dump_data = regs_q[dump_addr_q];
      if (ZERO_R0 && (dump_addr_q == '0)) begin
         dump_data = '0;
      end
   end

   // Dump sequencer: state and all handshake outputs registered together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         dump_addr_q  <= '0;
         dump_valid_q <= 1'b0;
         dump_busy_q  <= 1'b0;
         dump_done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               dump_done_q <= 1'b0;
               if (dump_start) begin
                  state_q      <= StScan;
                  dump_addr_q  <= '0;
                  dump_valid_q <= 1'b1;
                  dump_busy_q  <= 1'b1;
               end
            end
            StScan: begin
               if (dump_ready) begin
                  if (dump_addr_q == LastIdx) begin
                     state_q      <= StDone;
                     dump_addr_q  <= '0;
                     dump_valid_q <= 1'b0;
                     dump_busy_q  <= 1'b0;
                     dump_done_q  <= 1'b1;
                  end else begin
                     dump_addr_q <= dump_addr_q + 1'b1;
                  end
               end
            end
            StDone: begin
               state_q     <= StIdle;
               dump_done_q <= 1'b0;
            end
            default: begin
               state_q      <= StIdle;
               dump_valid_q <= 1'b0;
               dump_busy_q  <= 1'b0;
               dump_done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dump_addr  = dump_addr_q;
   assign dump_valid = dump_valid_q;
   assign dump_busy  = dump_busy_q;
   assign dump_done  = dump_done_q;

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 32, data width of every register in bits (>=8).
REQ-002 Parameter DEPTH, default 32, register count; power of two, >=4; AW = log2(DEPTH) is derived, not set.
REQ-003 Parameter IO_REG, default 30, index of the register mirrored to io_out and loadable from io_in; must be < DEPTH.
REQ-004 Parameter ZERO_R0, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-005 Port list (clock and reset first):
  clk  input  1  rising-edge clock for all state
  reset_n  input  1  asynchronous, active-low reset
  we  input  1  write enable for the write port
  writeaddr  input  AW  write address
  writedata  input  WIDTH  write data
  readaddr1  input  AW  read port 1 address
  readaddr2  input  AW  read port 2 address
  readdata1  output  WIDTH  read port 1 data, combinational
  readdata2  output  WIDTH  read port 2 data, combinational
  io_in  input  WIDTH  external load value for register IO_REG
  io_load  input  1  load io_in into IO_REG this edge
  io_out  output  WIDTH  stored contents of IO_REG
  dump_start  input  1  request a full-file sequential dump
  dump_ready  input  1  consumer accepts the current dump beat
  dump_valid  output  1  dump beat present
  dump_addr  output  AW  index of the current dump beat
  dump_data  output  WIDTH  stored contents of register dump_addr
  dump_busy  output  1  dump in progress
  dump_done  output  1  one-cycle pulse after the last beat is accepted

Function
REQ-006 Write: on rising clk with we=1, register[writeaddr] <= writedata; suppressed for writeaddr=0 when ZERO_R0=1.
REQ-007 Read: readdataN = register[readaddrN]; forced to 0 for readaddrN=0 when ZERO_R0=1.
REQ-008 Bypass: if we=1, writeaddr=readaddrN and the write is not suppressed, readdataN = writedata in the same cycle; both ports bypass independently.
REQ-009 IO load: io_load=1 writes io_in into IO_REG on the edge; if we=1 targets IO_REG in the same cycle, io_load wins and the we write is discarded.
REQ-010 Read bypass (REQ-008) reflects only the we path, never io_load; io_load data is visible on reads the cycle after the edge.
REQ-011 io_out = stored IO_REG contents, no bypass; it changes only on the edge after a write or load.
REQ-012 Dump FSM states IDLE, SCAN, DONE; IDLE -> SCAN on dump_start=1, dump_addr <= 0.
REQ-013 In SCAN: dump_valid=1, dump_busy=1; dump_addr advances by 1 on each edge with dump_ready=1; dump_addr, dump_data held while dump_ready=0.
REQ-014 dump_data = stored register[dump_addr] (0 for index 0 when ZERO_R0=1), no bypass; a write to dump_addr during a stall appears on dump_data the next cycle.
REQ-015 SCAN -> DONE when the beat at dump_addr=DEPTH-1 is accepted; DONE lasts exactly one cycle with dump_done=1, dump_valid=0, dump_busy=0, then -> IDLE.
REQ-016 dump_start is ignored in SCAN and DONE; a dump_start held high in IDLE after DONE starts a new dump.
REQ-017 Exactly DEPTH beats per dump, addresses 0..DEPTH-1 in order; the register port operates normally throughout a dump.

Reset
REQ-018 reset_n=0 asynchronously clears every register, io_out=0, FSM=IDLE, dump_addr=0, dump_valid=0, dump_busy=0, dump_done=0.
REQ-019 Reset asserted mid-dump aborts the dump with no dump_done pulse; operation resumes on the first rising clk after reset_n returns to 1.

Verification
REQ-020 Reset, then we=1, writeaddr=5, writedata=32'hDEADBEEF, readaddr1=5 -> readdata1=32'hDEADBEEF in the same cycle (bypass) and after the edge with we=0.
REQ-021 ZERO_R0=1: write 32'hFFFFFFFF to address 0 -> readdata1 and readdata2 at address 0 both read 0, with and without we.
REQ-022 Same edge: io_load=1, io_in=32'h0003FFFF, we=1, writeaddr=30, writedata=32'h12345678 -> after edge io_out=32'h0003FFFF, readdata2 (addr 30)=32'h0003FFFF.
REQ-023 Fill register i with i*16'h0101, pulse dump_start, dump_ready=1 -> 32 beats addresses 0..31 with matching data, then dump_done for one cycle, total 33 cycles start to done.
REQ-024 Dump with dump_ready toggling every other cycle and reset_n low at beat 10 -> beats held while stalled, outputs cleared immediately on reset, no dump_done pulse.
REQ-025 WIDTH=16, DEPTH=8, IO_REG=6 instance -> REQ-020..REQ-023 pass with 8-beat dump and 3-bit addresses.
